// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types, lookup tables and helpers for the inverse ASCON
// permutation (ascon_inv_permutation and ascon_inv_round).
package ascon_pkg;

  // Five 64-bit words; element 0 is x0.
  typedef logic [0:4][63:0] t_state_array;

  // 5-bit S-box table, entry v is the image of v ({x0..x4}, x0 = MSB).
  typedef logic [0:31][4:0] t_substitution;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_inv_fsm;

  // Round constants of p12, applied to x2[7:0]; p^a uses indices 12-a..11.
  localparam logic [0:11][7:0] C_LUT_ADDITION = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam t_substitution C_LUT_SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam t_substitution C_LUT_INV_SBOX = {
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  function automatic logic [63:0] f_rotr(input logic [63:0] x, input logic [5:0] k);
    logic [127:0] d;
    d = {x, x} >> k;
    return d[63:0];
  endfunction

  function automatic logic [63:0] f_rotl(input logic [63:0] x, input logic [5:0] k);
    logic [127:0] d;
    d = {x, x} << k;
    return d[127:64];
  endfunction

  // Product of two rotation masks (bit k = rotate by k): exponents add mod 64.
  function automatic logic [63:0] f_cyc_mul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) r = r ^ f_rotl(b, 6'(i));
    end
    return r;
  endfunction

  // L = 1 + X^r1 + X^r2 satisfies L^64 = 1, so L^-1 = L^63 = prod_k L^(2^k),
  // and L^(2^k) = 1 + X^(r1*2^k) + X^(r2*2^k).
  function automatic logic [63:0] f_inv_lin_mask(input int unsigned r1, input int unsigned r2);
    logic [63:0] acc;
    logic [63:0] term;
    acc = 64'h1;
    for (int k = 0; k < 6; k++) begin
      term = 64'h1;
      term = term ^ (64'h1 << ((r1 << k) % 64));
      term = term ^ (64'h1 << ((r2 << k) % 64));
      acc  = f_cyc_mul(acc, term);
    end
    return acc;
  endfunction

  // Per word: bit k set means rotr(x_i, k) contributes to the inverse.
  localparam logic [0:4][63:0] C_INV_LIN_MASK = {
    f_inv_lin_mask(19, 28),
    f_inv_lin_mask(61, 39),
    f_inv_lin_mask(1, 6),
    f_inv_lin_mask(10, 17),
    f_inv_lin_mask(7, 41)
  };

  // Constant for index idx; indices past 11 contribute nothing.
  function automatic logic [7:0] f_round_const(input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h00;
    if (idx < 4'd12) c = C_LUT_ADDITION[idx];
    return c;
  endfunction

endpackage

// File: rtl/ascon_inv_round.sv
// ascon_inv_round: one combinational inverse ASCON round.
// Order: inverse linear diffusion, inverse S-box, constant XOR on x2[7:0].
module ascon_inv_round
  import ascon_pkg::*;
(
  input  t_state_array i_state,
  input  logic [3:0]   i_idx,
  output t_state_array o_state
);

  t_state_array lin;
  t_state_array sub;
  logic [4:0]   col;
  logic [4:0]   res;

  // Inverse linear layer: XOR of the rotations selected by each word's mask.
  always_comb begin
    // NOTE: every combinational variable gets a default before conditional updates, so no latch is inferred.
    lin = '0;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 64; k++) begin
        if (C_INV_LIN_MASK[w][k]) lin[w] = lin[w] ^ f_rotr(i_state[w], 6'(k));
      end
    end
  end

  // Inverse S-box applied to each 5-bit column, x0 as MSB.
  always_comb begin
    sub = '0;
    col = '0;
    res = '0;
    for (int j = 0; j < 64; j++) begin
      col = {lin[0][j], lin[1][j], lin[2][j], lin[3][j], lin[4][j]};
      res = C_LUT_INV_SBOX[col];
      sub[0][j] = res[4];
      sub[1][j] = res[3];
      sub[2][j] = res[2];
      sub[3][j] = res[1];
      sub[4][j] = res[0];
    end
  end

  // Round-constant XOR on the low byte of x2.
  always_comb begin
    o_state       = sub;
    o_state[2][7:0] = sub[2][7:0] ^ f_round_const(i_idx);
  end

endmodule

// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation: iterative inverse of ASCON p^a (a = 1..12).
// Optional macro ASCON_INV_TWO_ROUNDS_EN chains two inverse rounds per clock.
module ascon_inv_permutation
  import ascon_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [3:0]   i_round_count,
  input  t_state_array i_state,
  output t_state_array o_state,
  output logic         o_valid,
  output logic         o_busy
);

  t_inv_fsm     fsm_q, fsm_d;
  t_state_array state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   rem_q, rem_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic [3:0]   rounds_sat;
  t_state_array round0;

  assign rounds_sat = (i_round_count > 4'd12) ? 4'd12 : i_round_count;

  ascon_inv_round u_round0 (
    .i_state (state_q),
    .i_idx   (idx_q),
    .o_state (round0)
  );

`ifdef ASCON_INV_TWO_ROUNDS_EN
  t_state_array round1;
  logic [3:0]   idx_m1;

  assign idx_m1 = idx_q - 4'd1;

  ascon_inv_round u_round1 (
    .i_state (round0),
    .i_idx   (idx_m1),
    .o_state (round1)
  );
`endif

  // Next-state logic: accept a start in IDLE, peel rounds in RUN, pulse in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (fsm_q)
      IDLE: begin
        if (i_start) begin
          state_d = i_state;
          idx_d   = 4'd11;
          rem_d   = rounds_sat;
          if (rounds_sat == 4'd0) begin
            fsm_d   = DONE;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            fsm_d  = RUN;
            busy_d = 1'b1;
          end
        end
      end
      RUN: begin
`ifdef ASCON_INV_TWO_ROUNDS_EN
        // An odd remainder finishes with the first instance only.
        if (rem_q == 4'd1) begin
          state_d = round0;
          rem_d   = 4'd0;
        end else begin
          state_d = round1;
          rem_d   = rem_q - 4'd2;
        end
        idx_d = idx_q - 4'd2;
        if (rem_q <= 4'd2) begin
`else
        state_d = round0;
        rem_d   = rem_q - 4'd1;
        idx_d   = idx_q - 4'd1;
        if (rem_q == 4'd1) begin
`endif
          fsm_d   = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // Registers: FSM, working state, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_state = state_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// tb_ascon_inv_permutation: randomized self-checking bench. A forward ASCON
// model (bitwise S-box, rotation linear layer, arithmetic constants) builds
// each DUT input from a known pre-image; a per-cycle monitor checks timing and
// results. Honours ASCON_INV_TWO_ROUNDS_EN for the expected latency.
module tb_ascon_inv_permutation;
  import ascon_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         i_start;
  logic [3:0]   i_round_count;
  t_state_array i_state;
  t_state_array o_state;
  logic         o_valid;
  logic         o_busy;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;

  // Scoreboard for the operation currently in flight.
  bit           mon_en   = 0;
  bit           active   = 0;
  int           e0       = 0;
  int           lat      = 0;
  t_state_array exp_state = '0;

  ascon_inv_permutation dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_round_count (i_round_count),
    .i_state       (i_state),
    .o_state       (o_state),
    .o_valid       (o_valid),
    .o_busy        (o_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // ---------------- forward reference model ----------------
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int k);
    return (k == 0) ? x : ((x >> k) | (x << (64 - k)));
  endfunction

  function automatic t_state_array sbox_layer(input t_state_array s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic t_state_array lin_layer(input t_state_array s);
    t_state_array r;
    r[0] = s[0] ^ rotr64(s[0], 19) ^ rotr64(s[0], 28);
    r[1] = s[1] ^ rotr64(s[1], 61) ^ rotr64(s[1], 39);
    r[2] = s[2] ^ rotr64(s[2], 1)  ^ rotr64(s[2], 6);
    r[3] = s[3] ^ rotr64(s[3], 10) ^ rotr64(s[3], 17);
    r[4] = s[4] ^ rotr64(s[4], 7)  ^ rotr64(s[4], 41);
    return r;
  endfunction

  function automatic int sat12(input int a);
    return (a > 12) ? 12 : a;
  endfunction

  // Forward p^a: round i uses constant ((15-i)<<4)|i for i = 12-a .. 11.
  function automatic t_state_array fwd_perm(input t_state_array s, input int a);
    t_state_array r;
    r = s;
    for (int i = 12 - a; i < 12; i++) begin
      r[2] = r[2] ^ 64'(((15 - i) << 4) | i);
      r    = lin_layer(sbox_layer(r));
    end
    return r;
  endfunction

  function automatic int lat_of(input int a);
`ifdef ASCON_INV_TWO_ROUNDS_EN
    return (sat12(a) + 1) / 2;
`else
    return sat12(a);
`endif
  endfunction

  function automatic logic [4:0] sbox_bits(input logic [4:0] v);
    t_state_array s;
    s = '0;
    s[0][0] = v[4]; s[1][0] = v[3]; s[2][0] = v[2]; s[3][0] = v[1]; s[4][0] = v[0];
    s = sbox_layer(s);
    return {s[0][0], s[1][0], s[2][0], s[3][0], s[4][0]};
  endfunction

  function automatic t_state_array rand_state();
    t_state_array r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  // ---------------- per-cycle monitor ----------------
  always @(negedge clock) begin : monitor
    logic ev;
    logic eb;
    if (mon_en) begin
      ev = active && (cyc == e0 + lat);
      eb = active && (lat > 0) && (cyc >= e0) && (cyc < e0 + lat);
      check("o_valid", {319'b0, o_valid}, {319'b0, ev});
      check("o_busy", {319'b0, o_busy}, {319'b0, eb});
      if (active && (cyc >= e0 + lat)) check("o_state", o_state, exp_state);
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input int a, input t_state_array pre, input bit extra);
    int wait_n;
    @(negedge clock); #1;
    i_state       = fwd_perm(pre, sat12(a));
    i_round_count = 4'(a);
    i_start       = 1'b1;
    e0            = cyc + 1;
    lat           = lat_of(a);
    exp_state     = pre;
    active        = 1'b1;
    @(negedge clock); #1;
    i_start = 1'b0;
    wait_n  = lat + 1;
    if (extra) begin
      for (int k = 0; k < 5; k++) begin
        i_start       = 1'b1;
        i_state       = rand_state();
        i_round_count = 4'($urandom_range(0, 15));
        @(negedge clock); #1;
      end
      i_start = 1'b0;
      wait_n  = wait_n - 5;
    end
    if (wait_n < 1) wait_n = 1;
    repeat (wait_n) @(negedge clock);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    t_state_array tmp;
    t_state_array pre;
    logic [4:0]   v5;

    reset_n       = 1'b0;
    i_start       = 1'b0;
    i_round_count = '0;
    i_state       = '0;
    #1;
    check("reset_o_state", o_state, '0);
    check("reset_o_valid", {319'b0, o_valid}, '0);
    check("reset_o_busy", {319'b0, o_busy}, '0);

    // Pin the reference model with hand-computed values.
    check("model_sbox_00", {315'b0, sbox_bits(5'h00)}, {315'b0, 5'h04});
    check("model_sbox_01", {315'b0, sbox_bits(5'h01)}, {315'b0, 5'h0b});
    check("model_sbox_14", {315'b0, sbox_bits(5'h14)}, {315'b0, 5'h00});
    check("model_sbox_1f", {315'b0, sbox_bits(5'h1f)}, {315'b0, 5'h17});
    tmp    = '0;
    tmp[0] = 64'h1;
    tmp[1] = 64'h1;
    tmp    = lin_layer(tmp);
    check("model_lin_x0", {256'b0, tmp[0]}, {256'b0, 64'h0000_2010_0000_0001});
    check("model_lin_x1", {256'b0, tmp[1]}, {256'b0, 64'h0000_0000_0200_0009});
    tmp    = '0;
    tmp[2] = 64'hf0;
    tmp    = sbox_layer(tmp);
    check("model_const_sbox", tmp,
          {64'hf0, 64'hf0, 64'hffff_ffff_ffff_ff0f, 64'hf0, 64'h0});

    // Inverse S-box table against the model and the forward table.
    v5 = 5'h04;
    check("inv_sbox_04", {315'b0, C_LUT_INV_SBOX[v5]}, '0);
    for (int v = 0; v < 32; v++) begin
      check("inv_sbox_vs_model", {315'b0, C_LUT_INV_SBOX[sbox_bits(5'(v))]}, 320'(v));
      check("inv_sbox_vs_fwd", {315'b0, C_LUT_INV_SBOX[C_LUT_SBOX[v]]}, 320'(v));
    end

    repeat (3) @(negedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // a = 0 passthrough.
    run_op(0, {64'h1, 64'h2, 64'h3, 64'h4, 64'h5}, 1'b0);
    // a = 12 from the forward image of the zero state.
    run_op(12, '0, 1'b0);
    check("a12_zero_result", o_state, '0);

    // Random pre-images at a = 6 and a = 8.
    for (int n = 0; n < 100; n++) begin
      run_op(6, rand_state(), 1'b0);
      run_op(8, rand_state(), 1'b0);
    end

    // Saturation and a spread of round counts.
    run_op(13, rand_state(), 1'b0);
    run_op(15, rand_state(), 1'b0);
    for (int n = 0; n < 16; n++) run_op(n, rand_state(), 1'b0);

    // Starts during a run must be ignored.
    run_op(12, rand_state(), 1'b1);

    // Reset asserted just before edge E0+5 of an a = 12 run.
    @(negedge clock); #1;
    pre           = rand_state();
    i_state       = fwd_perm(pre, 12);
    i_round_count = 4'd12;
    i_start       = 1'b1;
    e0            = cyc + 1;
    lat           = lat_of(12);
    exp_state     = pre;
    active        = 1'b1;
    @(negedge clock); #1;
    i_start = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    active  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_o_state", o_state, '0);
    check("midrun_reset_o_valid", {319'b0, o_valid}, '0);
    check("midrun_reset_o_busy", {319'b0, o_busy}, '0);
    repeat (3) @(negedge clock);
    #1;
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("post_reset_o_state", o_state, '0);

    // Recovery after reset.
    run_op(7, rand_state(), 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
